// File: rtl/gps_spi_rx.sv
// gps_spi_rx
// SPI slave receiver for the GPS sample link (MCU_SCK/MCU_SS/MCU_MOSI).
// The SPI lines are oversampled in the MCU_CLK_25_000 domain, and bytes are
// deframed in mode 0, MSB first. Received bytes go into a small FIFO. Each
// byte is then handed out as two 4-bit samples {I0,I1,Q0,Q1}, high nibble
// first, on a valid/ready stream.
//
// Ports
//   MCU_CLK_25_000  in   sole clock, rising edge
//   MCU_RESET_N     in   asynchronous active-low reset
//   MCU_SCK/SS/MOSI in   SPI lines, asynchronous to MCU_CLK_25_000
//   SAMPLE_DATA     out  4-bit sample, bit3 = I0
//   SAMPLE_VALID    out  a sample is presented
//   SAMPLE_READY    in   consumer accepts (transfer on VALID & READY)
//   FIFO_LEVEL      out  bytes currently buffered
//   OVERFLOW        out  sticky, a byte was dropped because the FIFO was full
//   FRAME_ERR       out  sticky, SS was released mid-byte
//   CLR_STATUS      in   pulse that clears the sticky flags and the counters
//   OVERFLOW_CNT    out  saturating drop counter (GPS_SPI_RX_STATS_EN only)
//   FRAME_ERR_CNT   out  saturating framing error counter (GPS_SPI_RX_STATS_EN only)
//
// Optional build macro: GPS_SPI_RX_STATS_EN adds the two 8-bit event counters.
//
// Receive FSM
//   state   | meaning
//   S_IDLE  | SS_s high: SCK edges are ignored and bit_cnt is held at 0
//   S_SHIFT | SS_s low: shift on each synchronised SCK rising edge

module gps_spi_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               MCU_CLK_25_000,
   input  logic               MCU_RESET_N,
   input  logic               MCU_SCK,
   input  logic               MCU_SS,
   input  logic               MCU_MOSI,
   output logic [3:0]         SAMPLE_DATA,
   output logic               SAMPLE_VALID,
   input  logic               SAMPLE_READY,
   output logic [LEVEL_W-1:0] FIFO_LEVEL,
   output logic               OVERFLOW,
   output logic               FRAME_ERR,
`ifdef GPS_SPI_RX_STATS_EN
   output logic [7:0]         OVERFLOW_CNT,
   output logic [7:0]         FRAME_ERR_CNT,
`endif
   input  logic               CLR_STATUS
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {S_IDLE, S_SHIFT} rx_state_t;

   logic sck_s1, sck_s2, sck_s3;
   logic ss_s1, ss_s2;
   logic mosi_s1, mosi_s2;
   logic sck_rise;

   rx_state_t state, state_nxt;
   logic [2:0] bit_cnt;
   logic [6:0] sr;
   logic       shift_en, byte_done_evt, frame_err_evt;
   logic       byte_rdy;
   logic [7:0] byte_q;
   logic       push_en;
   logic [7:0] push_byte;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [LEVEL_W-1:0] count;
   logic               full, empty, pop, wr_ok, ovf_evt;
   logic               phase;
   logic [7:0]         head;

   // The sync flops preset to the idle bus state, so a reset never shows up
   // as a false SS edge or SCK edge.
   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) begin
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_s3  <= 1'b0;
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sck_s1  <= MCU_SCK;
         sck_s2  <= sck_s1;
         sck_s3  <= sck_s2;
         ss_s1   <= MCU_SS;
         ss_s2   <= ss_s1;
         mosi_s1 <= MCU_MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sck_rise = sck_s2 & ~sck_s3;

   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      shift_en      = 1'b0;
      byte_done_evt = 1'b0;
      frame_err_evt = 1'b0;
      case (state)
         S_IDLE: begin
            if (!ss_s2) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (ss_s2) begin
               state_nxt     = S_IDLE;
               frame_err_evt = (bit_cnt != 3'd0);
            end else if (sck_rise) begin
               shift_en      = 1'b1;
               byte_done_evt = (bit_cnt == 3'd7);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A completed byte takes two register stages to reach the FIFO write
   // port, which sets the fixed SCK-to-SAMPLE_VALID latency.
   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) begin
         bit_cnt   <= 3'd0;
         sr        <= 7'd0;
         byte_rdy  <= 1'b0;
         byte_q    <= 8'd0;
         push_en   <= 1'b0;
         push_byte <= 8'd0;
      end else begin
         if (state_nxt == S_IDLE) bit_cnt <= 3'd0;
         else if (shift_en)       bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) sr <= {sr[5:0], mosi_s2};
         byte_rdy <= byte_done_evt;
         if (byte_done_evt) byte_q <= {sr, mosi_s2};
         push_en   <= byte_rdy;
         push_byte <= byte_q;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == LEVEL_W'(FIFO_DEPTH));
   assign pop   = SAMPLE_VALID & SAMPLE_READY & phase;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still lands.
   assign wr_ok   = push_en & (~full | pop);
   assign ovf_evt = push_en & full & ~pop;

   always_ff @(posedge MCU_CLK_25_000) begin
      if (wr_ok) mem[wr_ptr] <= push_byte;
   end

   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         phase  <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (SAMPLE_VALID && SAMPLE_READY) phase <= ~phase;
      end
   end

   assign head         = mem[rd_ptr];
   assign SAMPLE_VALID = ~empty;
   assign SAMPLE_DATA  = empty ? 4'd0 : (phase ? head[3:0] : head[7:4]);
   assign FIFO_LEVEL   = count;

   // A new event in the same cycle as CLR_STATUS takes priority.
   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) begin
         OVERFLOW  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (ovf_evt)         OVERFLOW <= 1'b1;
         else if (CLR_STATUS) OVERFLOW <= 1'b0;
         if (frame_err_evt)   FRAME_ERR <= 1'b1;
         else if (CLR_STATUS) FRAME_ERR <= 1'b0;
      end
   end

`ifdef GPS_SPI_RX_STATS_EN
   always_ff @(posedge MCU_CLK_25_000 or negedge MCU_RESET_N) begin
      if (!MCU_RESET_N) begin
         OVERFLOW_CNT  <= 8'd0;
         FRAME_ERR_CNT <= 8'd0;
      end else begin
         if (ovf_evt) begin
            if (CLR_STATUS)                OVERFLOW_CNT <= 8'd1;
            else if (OVERFLOW_CNT != 8'hFF) OVERFLOW_CNT <= OVERFLOW_CNT + 8'd1;
         end else if (CLR_STATUS) begin
            OVERFLOW_CNT <= 8'd0;
         end
         if (frame_err_evt) begin
            if (CLR_STATUS)                 FRAME_ERR_CNT <= 8'd1;
            else if (FRAME_ERR_CNT != 8'hFF) FRAME_ERR_CNT <= FRAME_ERR_CNT + 8'd1;
         end else if (CLR_STATUS) begin
            FRAME_ERR_CNT <= 8'd0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gps_spi_rx.sv
module tb_gps_spi_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck = 1'b0, ss = 1'b1, mosi = 1'b0;
   logic       ready = 1'b0, clr = 1'b0;
   logic [3:0] data;
   logic       valid;
   logic [3:0] level;
   logic       ovf, ferr;
`ifdef GPS_SPI_RX_STATS_EN
   logic [7:0] ovf_cnt, ferr_cnt;
`endif

   gps_spi_rx #(.FIFO_DEPTH(8)) dut (
      .MCU_CLK_25_000(clk),
      .MCU_RESET_N   (rst_n),
      .MCU_SCK       (sck),
      .MCU_SS        (ss),
      .MCU_MOSI      (mosi),
      .SAMPLE_DATA   (data),
      .SAMPLE_VALID  (valid),
      .SAMPLE_READY  (ready),
      .FIFO_LEVEL    (level),
      .OVERFLOW      (ovf),
      .FRAME_ERR     (ferr),
`ifdef GPS_SPI_RX_STATS_EN
      .OVERFLOW_CNT  (ovf_cnt),
      .FRAME_ERR_CNT (ferr_cnt),
`endif
      .CLR_STATUS    (clr)
   );

   always #20 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;
   bit mon_en  = 0;
   bit rand_ready = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [7:0] din;
      logic [3:0] exp_hi;
      logic [3:0] exp_lo;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference stream: every byte accepted by the link becomes its high
   // nibble then its low nibble, in order. Checked on every transfer.
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         hs_cnt++;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_sample: got %0h required none", data);
            end else begin
               check("stream_nibble", data, exp_q.pop_front());
            end
         end
      end
   end

   // READY only changes a little after the rising edge, well clear of the
   // negedge sampling above.
   initial begin
      forever begin
         @(posedge clk);
         #5;
         if (rand_ready) ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic set_ready(input logic v);
      @(posedge clk);
      #5;
      ready = v;
   endtask

   task automatic spi_bit(input logic b);
      mosi = b;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic ss_low();
      @(negedge clk);
      ss = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ss_high();
      @(negedge clk);
      ss = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
   endtask

   task automatic wait_valid(input int maxc);
      for (int i = 0; i < maxc && !valid; i++) @(negedge clk);
      check("wait_valid", valid, 1);
   endtask

   task automatic wait_drain(input string name, input int maxc);
      for (int i = 0; i < maxc && (exp_q.size() != 0 || valid); i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      int hs0;

      vecs[0] = '{8'h00, 4'h0, 4'h0};
      vecs[1] = '{8'hFF, 4'hF, 4'hF};
      vecs[2] = '{8'h3C, 4'h3, 4'hC};
      vecs[3] = '{8'h81, 4'h8, 4'h1};
      vecs[4] = '{8'h7E, 4'h7, 4'hE};

      // Reset values
      #5;
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_level", level, 0);
      check("rst_ovf", ovf, 0);
      check("rst_ferr", ferr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // SCK activity with SS high must be ignored
      spi_byte(8'($urandom));
      spi_byte(8'($urandom));
      repeat (8) @(negedge clk);
      check("ss_high_valid", valid, 0);
      check("ss_high_level", level, 0);
      check("ss_high_ovf", ovf, 0);
      check("ss_high_ferr", ferr, 0);

      // 0xA5 with READY high: latency and exactly two transfers
      mon_en = 1;
      push_exp(8'hA5);
      set_ready(1'b1);
      hs0 = hs_cnt;
      ss_low();
      b = 8'hA5;
      for (int i = 7; i >= 1; i--) spi_bit(b[i]);
      mosi = b[0];
      repeat (2) @(negedge clk);
      sck = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 2) sck = 1'b0;
         if (k == 4) check("latency_before", valid, 0);
         if (k == 5) check("latency_at", valid, 1);
      end
      repeat (10) @(negedge clk);
      check("a5_handshakes", hs_cnt - hs0, 2);
      check("a5_exp_empty", exp_q.size(), 0);
      check("a5_valid_low", valid, 0);
      set_ready(1'b0);

      // Table-driven single bytes with manual handshakes
      mon_en = 0;
      foreach (vecs[v]) begin
         spi_byte(vecs[v].din);
         wait_valid(20);
         check("tbl_hi", data, vecs[v].exp_hi);
         set_ready(1'b1);
         set_ready(1'b0);
         @(negedge clk);
         check("tbl_lo", data, vecs[v].exp_lo);
         check("tbl_lo_valid", valid, 1);
         set_ready(1'b1);
         set_ready(1'b0);
         @(negedge clk);
         check("tbl_empty", valid, 0);
      end

      // Overflow: 9 bytes into an 8-deep FIFO with READY low
      mon_en = 1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) push_exp(8'(i));
         spi_byte(8'(i));
      end
      repeat (6) @(negedge clk);
      check("ovf_level", level, 8);
      check("ovf_flag", ovf, 1);
      check("ovf_no_ferr", ferr, 0);
`ifdef GPS_SPI_RX_STATS_EN
      check("ovf_cnt", ovf_cnt, 1);
`endif
      pulse_clr();
      check("ovf_cleared", ovf, 0);
`ifdef GPS_SPI_RX_STATS_EN
      check("ovf_cnt_cleared", ovf_cnt, 0);
`endif

      // FIFO full: a pop lands in the same cycle as the next push
      push_exp(8'h9B);
      b = 8'h9B;
      for (int i = 7; i >= 1; i--) spi_bit(b[i]);
      mosi = b[0];
      repeat (2) @(negedge clk);
      sck = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      sck = 1'b0;
      @(posedge clk);
      #5 ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #5 ready = 1'b0;
      @(negedge clk);
      check("simul_level", level, 8);
      check("simul_no_ovf", ovf, 0);
      rand_ready = 1;
      wait_drain("simul_drain", 600);
      check("simul_level_zero", level, 0);
      rand_ready = 0;

      // Framing error: 5 bits then SS released, then a good byte
      set_ready(1'b1);
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      ss_high();
      check("ferr_flag", ferr, 1);
      check("ferr_level", level, 0);
`ifdef GPS_SPI_RX_STATS_EN
      check("ferr_cnt", ferr_cnt, 1);
`endif
      ss_low();
      push_exp(8'h3C);
      spi_byte(8'h3C);
      wait_drain("ferr_drain", 100);
      check("ferr_sticky", ferr, 1);
      pulse_clr();
      check("ferr_cleared", ferr, 0);

      // Reset mid-unpack (phase 1) and mid-byte
      set_ready(1'b0);
      push_exp(8'h96);
      spi_byte(8'h96);
      wait_valid(20);
      set_ready(1'b1);
      set_ready(1'b0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) spi_bit(1'b1);
      #7 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid, 0);
      check("mid_rst_data", data, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_flags", {ovf, ferr}, 0);
      exp_q.delete();
      sck = 1'b0;
      ss = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      set_ready(1'b1);
      ss_low();
      push_exp(8'h5E);
      spi_byte(8'h5E);
      wait_drain("post_rst_drain", 100);
      check("post_rst_no_ferr", ferr, 0);

      // Randomised byte stream against the nibble reference
      rand_ready = 1;
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom);
         push_exp(b);
         spi_byte(b);
         repeat ($urandom_range(0, 6)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            ss_high();
            ss_low();
         end
      end
      wait_drain("rand_drain", 400);
      check("rand_level", level, 0);
      check("rand_ovf", ovf, 0);
      check("rand_ferr", ferr, 0);
      rand_ready = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
